// File: rtl/clb_cfg_loader.sv
// ---------------------------------------------------------------------------------------------
// clb_cfg_loader
//
// Serial configuration loader for one CLB tile. Frames arrive on a daisy-chained config chain.
// Each frame has an ID header (MSB first) followed by a payload (bit k -> cfg[k]). A frame whose
// header matches this tile, or the all-ones broadcast ID when enabled, is shifted into a shadow
// register. The shadow register is copied onto the cfg bus in a single cycle, so the CLB never
// sees a half-loaded word. All chain traffic is forwarded, one cycle late, to the next tile.
//
// Ports:
//   clk            global clock
//   rst_n          synchronous reset, active low
//   cfg_in_start   frame start strobe from upstream
//   cfg_bit_in     serial config data from upstream
//   cfg_out_start  cfg_in_start delayed one cycle, to downstream
//   cfg_bit_out    cfg_bit_in delayed one cycle, to downstream
//   cfg            committed configuration word driving the CLB
//   cfg_valid      set once any frame has committed since reset
//   busy           high while a frame is in header, payload or commit
// ---------------------------------------------------------------------------------------------
module clb_cfg_loader #(
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned ID       = 0,
  parameter int unsigned CFG_SIZE = 256,
  parameter int unsigned BCAST_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_in_start,
  input  logic                cfg_bit_in,
  output logic                cfg_out_start,
  output logic                cfg_bit_out,
  output logic [CFG_SIZE-1:0] cfg,
  output logic                cfg_valid,
  output logic                busy
);

  localparam int unsigned CntW    = $clog2(CFG_SIZE + 1);
  localparam int unsigned IdxW    = (CFG_SIZE > 1) ? $clog2(CFG_SIZE) : 1;
  localparam int unsigned HdrCntW = $clog2(ID_WIDTH + 1);

  localparam logic [CntW-1:0]     LastBit = CntW'(CFG_SIZE - 1);
  localparam logic [HdrCntW-1:0]  LastHdr = HdrCntW'(ID_WIDTH - 1);
  localparam logic [ID_WIDTH-1:0] TileId  = ID_WIDTH'(ID);
  localparam logic [ID_WIDTH-1:0] BcastId = '1;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPayload,
    StCommit
  } state_e;

  // A one-bit header is complete on the start cycle itself, so the frame skips straight to payload.
  localparam state_e StFirst = (ID_WIDTH == 1) ? StPayload : StHdr;

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0] hdr_q;
  logic [HdrCntW-1:0]  hdr_cnt_q;
  logic [CntW-1:0]     cnt_q;
  logic                match_q;
  logic [CFG_SIZE-1:0] shadow_q;

  logic [ID_WIDTH-1:0] hdr_first;
  logic [ID_WIDTH-1:0] hdr_shift;

  // Decoded control strobes
  logic frame_start;
  logic hdr_en;
  logic pay_en;
  logic commit;

  function automatic logic is_match(input logic [ID_WIDTH-1:0] h);
    return (h == TileId) || ((BCAST_EN != 0) && (h == BcastId));
  endfunction

  assign hdr_first = ID_WIDTH'(cfg_bit_in);
  // Shift left, new bit enters at LSB; the oldest (MSB) bit ends up on top after ID_WIDTH bits.
  assign hdr_shift = ID_WIDTH'({hdr_q, cfg_bit_in});

  // ------------------------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------------------------------
  // Next-state logic. A start strobe restarts the frame from any state; from COMMIT the commit
  // itself still happens this cycle (see output logic).
  // ------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (cfg_in_start) begin
      state_d = StFirst;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StHdr: begin
          if (hdr_cnt_q == LastHdr) begin
            state_d = StPayload;
          end
        end
        StPayload: begin
          // Mismatched frames still run their full length before going idle.
          if (cnt_q == LastBit) begin
            state_d = match_q ? StCommit : StIdle;
          end
        end
        StCommit: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------------------------
  // Output / control decode
  // ------------------------------------------------------------------------------------------
  always_comb begin
    frame_start = cfg_in_start;
    hdr_en      = (state_q == StHdr) && !cfg_in_start;
    pay_en      = (state_q == StPayload) && !cfg_in_start;
    commit      = (state_q == StCommit);
  end

  // ------------------------------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_out_start <= 1'b0;
      cfg_bit_out   <= 1'b0;
      busy          <= 1'b0;
      hdr_q         <= '0;
      hdr_cnt_q     <= '0;
      cnt_q         <= '0;
      match_q       <= 1'b0;
      shadow_q      <= '0;
      cfg           <= '0;
      cfg_valid     <= 1'b0;
    end else begin
      // Chain pass-through is unconditional.
      cfg_out_start <= cfg_in_start;
      cfg_bit_out   <= cfg_bit_in;

      busy <= (state_d != StIdle);

      if (frame_start) begin
        hdr_q     <= hdr_first;
        hdr_cnt_q <= HdrCntW'(1);
        cnt_q     <= '0;
        // Only final for one-bit headers; otherwise overwritten as the header completes.
        match_q   <= is_match(hdr_first);
      end else if (hdr_en) begin
        hdr_q     <= hdr_shift;
        hdr_cnt_q <= hdr_cnt_q + HdrCntW'(1);
        match_q   <= is_match(hdr_shift);
      end else if (pay_en) begin
        if (match_q) begin
          shadow_q[cnt_q[IdxW-1:0]] <= cfg_bit_in;
        end
        cnt_q <= cnt_q + CntW'(1);
      end

      if (commit) begin
        cfg       <= shadow_q;
        cfg_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
module tb_clb_cfg_loader;

  localparam int unsigned IdW      = 3;
  localparam int unsigned TileId   = 2;
  localparam int unsigned CfgW     = 16;
  localparam int unsigned FrameLen = IdW + CfgW;
  localparam int unsigned MaxC     = 8192;

  logic clk = 1'b0;
  logic rst_n, cfg_in_start, cfg_bit_in;
  logic os_b, ob_b, v_b, busy_b;
  logic os_n, ob_n, v_n, busy_n;
  logic [CfgW-1:0] cfg_b, cfg_n;

  always #5 clk = ~clk;

  // Broadcast-enabled tile
  clb_cfg_loader #(.ID_WIDTH(IdW), .ID(TileId), .CFG_SIZE(CfgW), .BCAST_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_in_start(cfg_in_start), .cfg_bit_in(cfg_bit_in),
    .cfg_out_start(os_b), .cfg_bit_out(ob_b), .cfg(cfg_b), .cfg_valid(v_b), .busy(busy_b)
  );

  // Broadcast-disabled tile on the same chain inputs
  clb_cfg_loader #(.ID_WIDTH(IdW), .ID(TileId), .CFG_SIZE(CfgW), .BCAST_EN(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .cfg_in_start(cfg_in_start), .cfg_bit_in(cfg_bit_in),
    .cfg_out_start(os_n), .cfg_bit_out(ob_n), .cfg(cfg_n), .cfg_valid(v_n), .busy(busy_n)
  );

  typedef struct {
    int              due;
    logic [CfgW-1:0] val;
  } commit_t;

  commit_t q_b[$];
  commit_t q_n[$];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  bit rst_log[0:MaxC-1];
  bit st_log [0:MaxC-1];
  bit bit_log[0:MaxC-1];
  bit bexp_b [0:MaxC-1];
  bit bexp_n [0:MaxC-1];

  logic [CfgW-1:0] exp_cfg_b = '0;
  logic [CfgW-1:0] exp_cfg_n = '0;
  logic            exp_v_b   = 1'b0;
  logic            exp_v_n   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One chain cycle: apply inputs, log them, advance past the consuming edge.
  task automatic drive(input logic r, input logic st, input logic b);
    rst_n        = r;
    cfg_in_start = st;
    cfg_bit_in   = b;
    rst_log[cyc] = r;
    st_log[cyc]  = st;
    bit_log[cyc] = b;
    if (!r) begin
      for (int k = 1; k <= 40; k++) begin
        bexp_b[cyc+k] = 1'b0;
        bexp_n[cyc+k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'($urandom));
  endtask

  // Sends the first nbits of a frame. Only a complete frame can commit; a partial one must be
  // followed at once by another frame start or a reset.
  task automatic send_frame(input logic [IdW-1:0] h, input logic [CfgW-1:0] p, input int nbits);
    int      s;
    bit      mb, mn;
    commit_t e;
    s  = cyc;
    mn = (h == IdW'(TileId));
    mb = mn || (h == 3'b111);
    // Matching frames are busy through the commit cycle; others go idle after the last bit.
    for (int k = 1; k <= FrameLen; k++) begin
      bexp_b[s+k] = (k < FrameLen) || mb;
      bexp_n[s+k] = (k < FrameLen) || mn;
    end
    if (nbits == FrameLen) begin
      e.due = s + FrameLen + 1;
      e.val = p;
      if (mb) q_b.push_back(e);
      if (mn) q_n.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      drive(1'b1, i == 0, (i < IdW) ? h[IdW-1-i] : p[i-IdW]);
    end
  endtask

  // Monitor: pops expected commits as they fall due and checks every visible output.
  always @(negedge clk) begin
    int      c;
    commit_t keep[$];
    if (cyc >= 1) begin
      c = cyc;
      if (!rst_log[c-1]) begin
        exp_cfg_b = '0;
        exp_cfg_n = '0;
        exp_v_b   = 1'b0;
        exp_v_n   = 1'b0;
        // Frames started before the reset are aborted.
        keep = {};
        foreach (q_b[i]) if (q_b[i].due >= c + FrameLen + 1) keep.push_back(q_b[i]);
        q_b = keep;
        keep = {};
        foreach (q_n[i]) if (q_n[i].due >= c + FrameLen + 1) keep.push_back(q_n[i]);
        q_n = keep;
      end else begin
        if (q_b.size() > 0 && q_b[0].due == c) begin
          exp_cfg_b = q_b[0].val;
          exp_v_b   = 1'b1;
          void'(q_b.pop_front());
        end
        if (q_n.size() > 0 && q_n[0].due == c) begin
          exp_cfg_n = q_n[0].val;
          exp_v_n   = 1'b1;
          void'(q_n.pop_front());
        end
      end
      chk("cfg_bcast", 32'(cfg_b), 32'(exp_cfg_b));
      chk("valid_bcast", 32'(v_b), 32'(exp_v_b));
      chk("busy_bcast", 32'(busy_b), 32'(bexp_b[c]));
      chk("cfg_nobcast", 32'(cfg_n), 32'(exp_cfg_n));
      chk("valid_nobcast", 32'(v_n), 32'(exp_v_n));
      chk("busy_nobcast", 32'(busy_n), 32'(bexp_n[c]));
      chk("pass_start", 32'({os_b, os_n}), rst_log[c-1] ? 32'({2{st_log[c-1]}}) : 32'd0);
      chk("pass_bit", 32'({ob_b, ob_n}), rst_log[c-1] ? 32'({2{bit_log[c-1]}}) : 32'd0);
    end
  end

  initial begin
    logic [IdW-1:0]  h;
    logic [CfgW-1:0] p;

    // Reset with random chain activity
    drive(1'b0, 1'($urandom), 1'($urandom));
    drive(1'b0, 1'($urandom), 1'($urandom));
    idle(2);

    // Matching load
    send_frame(3'b010, 16'hA5C3, FrameLen);
    idle(3);

    // Mismatch, then broadcast (only the broadcast-enabled tile takes it)
    send_frame(3'b011, 16'hFFFF, FrameLen);
    idle(2);
    send_frame(3'b111, 16'h1234, FrameLen);
    idle(2);

    // Abort at payload bit 7, then a full frame
    send_frame(3'b010, 16'h5555, IdW + 7);
    send_frame(3'b010, 16'h0F0F, FrameLen);
    idle(2);

    // Back-to-back: second start lands on the commit cycle of the first
    send_frame(3'b010, 16'hBEEF, FrameLen);
    send_frame(3'b010, 16'hC0DE, FrameLen);
    idle(2);

    // Reset at payload bit 10 after a prior commit, then a normal load
    send_frame(3'b010, 16'h3C3C, FrameLen);
    idle(1);
    send_frame(3'b010, 16'h7777, IdW + 10);
    drive(1'b0, 1'($urandom), 1'($urandom));
    idle(2);
    send_frame(3'b010, 16'h9999, FrameLen);
    idle(2);

    // Randomized frames with occasional aborts
    for (int f = 0; f < 40; f++) begin
      h = ($urandom_range(0, 2) == 0) ? IdW'(TileId) : IdW'($urandom_range(0, 7));
      p = CfgW'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(h, p, $urandom_range(1, FrameLen - 1));
        send_frame(IdW'(TileId), CfgW'($urandom), FrameLen);
      end else begin
        send_frame(h, p, FrameLen);
      end
      idle($urandom_range(0, 3));
    end

    idle(FrameLen + 5);
    chk("drain_bcast", 32'(q_b.size()), 32'd0);
    chk("drain_nobcast", 32'(q_n.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
